coproc_io_bridge: RTL and testbench

Host-side request bridge that sits directly upstream of the core's coprocessor IO port. It accepts host read/write requests over a valid/ready interface and buffers them in a small FIFO. It then issues them one at a time as single-cycle strobes on `coprocessorIOAddr`/`coprocessorIOControl`/`coprocessorIODataOut`, captures `coprocessorIODataIn` after a fixed read latency, and returns one response per request in issue order.

---
 rtl/coproc_io_bridge.sv | 169 ++++++++++++++++
 tb/tb_coproc_io_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_io_bridge.sv
// Host request bridge: queues host reads/writes and issues them one at a time on the coprocessor IO port.
// Latency: strobe 2 cycles after accept; response at +3 for writes and unmapped requests, +3+READ_LAT for reads.
// Backpressure: req_ready = FIFO not full; resp_ready low stalls the FSM in RESP while the FIFO keeps filling.
//
// Ports: clk/reset (async, active-high); host request channel req_valid/req_ready/req_write/req_addr/req_data;
// host response channel resp_valid/resp_ready/resp_data/resp_err; busy; core side coprocessorIOAddr,
// coprocessorIOControl {halt, write strobe, read strobe}, coprocessorIODataOut, coprocessorIODataIn.
// Option macro COPROC_BRIDGE_HALT_EN: drive coprocessorIOControl[2] while busy and hold strobes until it is up.

module coproc_io_bridge #(
    parameter int N        = 64,
    parameter int DEPTH    = 4,
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [14:0]  req_addr,
    input  logic [N-1:0] req_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_data,
    output logic         resp_err,
    output logic         busy,
    output logic [14:0]  coprocessorIOAddr,
    output logic [2:0]   coprocessorIOControl,
    output logic [N-1:0] coprocessorIODataOut,
    input  logic [N-1:0] coprocessorIODataIn
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic         write;
        logic [14:0]  addr;
        logic [N-1:0] data;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    req_t        mem [DEPTH];
    req_t        head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        halt;
    logic        issue_ok;

    state_t      state;
    logic        cmd_write;
    logic        cmd_unmapped;
    logic [1:0]  strobe;
    logic [2:0]  lat_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full;
    // A push while full is refused even if the FSM pops the same cycle.
    assign push      = req_valid && !full;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign pop       = (state == S_IDLE) && !empty && issue_ok;
    assign busy      = !empty || (state != S_IDLE);

    assign coprocessorIOControl = {halt, strobe};

`ifdef COPROC_BRIDGE_HALT_EN
    // Halt follows busy by one cycle, so it rises before the first pop of a
    // burst and falls one cycle after the bridge goes idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt <= 1'b0;
        end else begin
            halt <= busy;
        end
    end
    assign issue_ok = halt;
`else
    assign halt     = 1'b0;
    assign issue_ok = 1'b1;
`endif

    // Storage is not reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{write: req_write, addr: req_addr, data: req_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            state                <= S_IDLE;
            cmd_write            <= 1'b0;
            cmd_unmapped         <= 1'b0;
            strobe               <= 2'b00;
            lat_cnt              <= 3'd0;
            resp_valid           <= 1'b0;
            resp_data            <= '0;
            resp_err             <= 1'b0;
            coprocessorIOAddr    <= '0;
            coprocessorIODataOut <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cmd_write    <= head.write;
                        cmd_unmapped <= (head.addr[14:12] == 3'b111);
                        state        <= S_ISSUE;
                        // Strobe and address are registered here so they are
                        // visible exactly during the ISSUE cycle.
                        if (head.addr[14:12] != 3'b111) begin
                            coprocessorIOAddr <= head.addr;
                            strobe            <= head.write ? 2'b10 : 2'b01;
                            if (head.write) begin
                                coprocessorIODataOut <= head.data;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    strobe <= 2'b00;
                    if (cmd_unmapped || cmd_write) begin
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                        resp_err   <= cmd_unmapped;
                        state      <= S_RESP;
                    end else begin
                        lat_cnt <= 3'(READ_LAT - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        resp_valid <= 1'b1;
                        resp_data  <= coprocessorIODataIn;
                        resp_err   <= 1'b0;
                        state      <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_io_bridge.sv
module tb_coproc_io_bridge;

    localparam int N        = 64;
    localparam int DEPTH    = 4;
    localparam int READ_LAT = 3;
`ifdef COPROC_BRIDGE_HALT_EN
    localparam int HX = 1;
`else
    localparam int HX = 0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          req_valid  = 1'b0;
    logic          req_write  = 1'b0;
    logic [14:0]   req_addr   = '0;
    logic [N-1:0]  req_data   = '0;
    logic          resp_ready = 1'b1;
    logic          req_ready;
    logic          resp_valid;
    logic [N-1:0]  resp_data;
    logic          resp_err;
    logic          busy;
    logic [14:0]   io_addr;
    logic [2:0]    io_ctl;
    logic [N-1:0]  io_dout;
    logic [N-1:0]  io_din     = '0;

    coproc_io_bridge #(.N(N), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_addr             (req_addr),
        .req_data             (req_data),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_data            (resp_data),
        .resp_err             (resp_err),
        .busy                 (busy),
        .coprocessorIOAddr    (io_addr),
        .coprocessorIOControl (io_ctl),
        .coprocessorIODataOut (io_dout),
        .coprocessorIODataIn  (io_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  ctl;
        logic [14:0] addr;
        logic [63:0] data;
        logic        w;
        int          due;
    } sexp_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
    } rexp_t;

    sexp_t sq[$];
    rexp_t rq[$];
    logic  resp_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed event did not occur within bound, required it to", tag);
    endtask

    // Core model: read data appears READ_LAT cycles after the read strobe,
    // and is junk in every other cycle so early or late capture shows up.
    function automatic logic [63:0] rdval(input logic [14:0] a);
        if (a == 15'h0100) return 64'h1234;
        return {17'h0, a, 32'hC0DE_0000};
    endfunction

    logic [READ_LAT:0] sh    = '0;
    logic [14:0]       saddr = '0;
    always @(negedge clk) begin
        sh = {sh[READ_LAT-1:0], io_ctl[0]};
        if (io_ctl[0]) saddr = io_addr;
        io_din = sh[READ_LAT] ? rdval(saddr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Strobe scoreboard: every strobe cycle must match the next expected access.
    always @(negedge clk) begin
        sexp_t se;
        if (!reset && io_ctl[1:0] != 2'b00) begin
            if (sq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL strobe_unexpected: observed control %0h addr %0h, required no strobe", io_ctl, io_addr);
            end else begin
                se = sq.pop_front();
                chk("strobe_ctl", 64'(io_ctl[1:0]), 64'(se.ctl));
                chk("strobe_addr", 64'(io_addr), 64'(se.addr));
                if (se.w) chk("strobe_dout", io_dout, se.data);
                if (se.due >= 0) chk("strobe_cycle", 64'(cyc), 64'(se.due));
            end
        end
    end

    // Response scoreboard: latency on first sight, payload at handshake.
    always @(negedge clk) begin
        rexp_t re;
        if (!reset && resp_valid) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL resp_unexpected: observed data %0h err %0b, required no response", resp_data, resp_err);
            end else begin
                if (!resp_seen && rq[0].due >= 0) chk("resp_cycle", 64'(cyc), 64'(rq[0].due));
                resp_seen = 1'b1;
                if (resp_ready) begin
                    re = rq.pop_front();
                    chk("resp_data", resp_data, re.data);
                    chk("resp_err", 64'(resp_err), 64'(re.err));
                    resp_seen = 1'b0;
                end
            end
        end
    end

    // Drives one request and returns the cycle in which it was accepted.
    task automatic send(input logic w, input logic [14:0] a, input logic [63:0] d, output int t);
        int   g   = 0;
        logic acc = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        t = -1;
        while (!acc && g < 100) begin
            @(negedge clk);
            acc = req_ready;
            t   = cyc;
            @(posedge clk);
            #1;
            g++;
        end
        req_valid = 1'b0;
        if (!acc) fail_now("send_accept");
    endtask

    task automatic expect_req(input logic w, input logic [14:0] a, input logic [63:0] d,
                              input int sdue, input int rdue);
        logic unm;
        unm = (a[14:12] == 3'b111);
        if (!unm) sq.push_back('{(w ? 2'b10 : 2'b01), a, d, w, sdue});
        rq.push_back('{((w || unm) ? 64'h0 : rdval(a)), unm, rdue});
    endtask

    // Single request; timed expectations only hold when issued from idle.
    task automatic req(input logic w, input logic [14:0] a, input logic [63:0] d, input logic timed);
        int  t;
        int  lat;
        send(w, a, d, t);
        lat = (w || a[14:12] == 3'b111) ? 3 : 3 + READ_LAT;
        expect_req(w, a, d, timed ? t + 2 + HX : -1, timed ? t + lat + HX : -1);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((rq.size() != 0 || sq.size() != 0 || busy) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 300) fail_now(tag);
    endtask

    initial begin
        int t;
        int t0;
        int k;
        logic acc;

        // Reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ctl", 64'(io_ctl), 64'd0);
        chk("rst_addr", 64'(io_addr), 64'd0);
        chk("rst_dout", io_dout, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single write
        req(1'b1, 15'h0040, 64'hDEADBEEF_CAFEF00D, 1'b1);
        wait_idle("write_drain");

        // Read latency
        req(1'b0, 15'h0100, 64'h0, 1'b1);
        wait_idle("read_drain");

        // Unmapped read, then a mapped read behind it
        req(1'b0, 15'h7000, 64'h0, 1'b1);
        req(1'b0, 15'h0200, 64'h0, 1'b0);
        wait_idle("unmapped_drain");

        // Back-to-back writes complete every 3 cycles
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 15'(15'h0020 + i), 64'hA5A5_0000_0000_0000 | 64'(i), t);
            if (i == 0) t0 = t;
            expect_req(1'b1, 15'(15'h0020 + i), 64'hA5A5_0000_0000_0000 | 64'(i),
                       t0 + 2 + HX + 3 * i, t0 + 3 + HX + 3 * i);
        end
        wait_idle("tput_drain");

        // FIFO full under response backpressure
        resp_ready = 1'b0;
        k = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'h0400;
        req_data  = 64'hF00D_0000_0000_0000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = req_ready;
            if (acc) expect_req(1'b1, req_addr, req_data, -1, -1);
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                req_addr = 15'(15'h0400 + k);
                req_data = 64'hF00D_0000_0000_0000 | 64'(k);
            end
        end
        req_valid = 1'b0;
        chk("full_accepts", 64'(k), 64'd5);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        resp_ready = 1'b1;
        wait_idle("full_drain");

        // Reset in the middle of a read wait with 3 requests queued
        send(1'b0, 15'h0300, 64'h0, t);
        sq.push_back('{2'b01, 15'h0300, 64'h0, 1'b0, t + 2 + HX});
        for (int i = 1; i < 4; i++) send(1'b0, 15'(15'h0300 + i), 64'h0, t0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_resp_data", resp_data, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ctl", 64'(io_ctl), 64'd0);
        chk("midrst_addr", 64'(io_addr), 64'd0);
        chk("midrst_dout", io_dout, 64'd0);
        chk("midrst_strobe_seen", 64'(sq.size()), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("postrst_req_ready", 64'(req_ready), 64'd1);

        // Bridge works normally after reset
        req(1'b0, 15'h0123, 64'h0, 1'b1);
        wait_idle("final_drain");
        chk("end_strobe_queue", 64'(sq.size()), 64'd0);
        chk("end_resp_queue", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
